// File: rtl/difftest_step_batcher.sv
// difftest_step_batcher
// Collects per-cycle instruction-commit pulses into batched step counts for
// the difftest endpoint, and turns a core trap event into the 64-bit exit
// code the endpoint consumes. Every commit is stepped before exit is raised.
//
// Ports:
//   clock          sole clock
//   reset          asynchronous, active-low reset
//   commit_valid   one bit per instruction committed this cycle
//   force_flush    emit all pending commits now
//   trap_valid     single-cycle pulse: core hit a trap instruction
//   trap_good      qualifies trap_valid (1 = good trap)
//   trap_code      trap code, valid with trap_valid
//   difftest_step  commits to step this cycle (0 = no step), registered
//   difftest_exit  0 = running, all-ones = good exit, else error code
//
// Optional feature macro: DIFFTEST_BATCH_STATS_EN
//   When defined, adds stat_batches (emit cycles with nonzero step, 32 bits)
//   and stat_commits (sum of emitted step values, 64 bits); both wrap.
module difftest_step_batcher #(
  parameter int NUM_PORTS       = 6,
  parameter int STEPWIDTH       = 8,
  parameter int BATCH_THRESHOLD = 32,
  parameter int FLUSH_TIMEOUT   = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] commit_valid,
  input  logic                 force_flush,
  input  logic                 trap_valid,
  input  logic                 trap_good,
  input  logic [31:0]          trap_code,
  output logic [STEPWIDTH-1:0] difftest_step,
  output logic [63:0]          difftest_exit
`ifdef DIFFTEST_BATCH_STATS_EN
  ,
  output logic [31:0]          stat_batches,
  output logic [63:0]          stat_commits
`endif
);

  // Pending/total width leaves two bits of headroom above a full step.
  localparam int PW = STEPWIDTH + 2;
  // Timer wide enough to reach FLUSH_TIMEOUT-1 and then saturate.
  localparam int TW = $clog2(FLUSH_TIMEOUT + 1) + 1;

  localparam logic [PW-1:0] STEP_MAX_P  = {2'b00, {STEPWIDTH{1'b1}}};
  localparam logic [PW-1:0] THRESHOLD_P = PW'(BATCH_THRESHOLD);
  localparam logic [TW-1:0] TIMEOUT_P   = TW'(FLUSH_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_MAX_P = {TW{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_EXIT  = 2'd2
  } state_t;

  state_t          state_r, state_nx_s;
  logic [PW-1:0]   pending_r, pending_nx_s;
  logic [TW-1:0]   timer_r, timer_nx_s;
  logic            good_r, good_nx_s;
  logic [31:0]     code_r, code_nx_s;
  logic [STEPWIDTH-1:0] step_nx_s;
  logic [63:0]     exit_nx_s;

  logic [PW-1:0]   inc_s;
  logic [PW-1:0]   total_s;
  logic [PW-1:0]   emit_val_s;
  logic [PW-1:0]   residual_s;
  logic            trap_s;
  logic            emit_s;

  // Number of set bits in the commit vector.
  function automatic logic [PW-1:0] popcount(input logic [NUM_PORTS-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      c = c + PW'(v[i]);
    end
    return c;
  endfunction

  // Batch arithmetic, emit decision, next state and next outputs.
  always_comb begin
    state_nx_s   = state_r;
    pending_nx_s = pending_r;
    timer_nx_s   = timer_r;
    good_nx_s    = good_r;
    code_nx_s    = code_r;
    step_nx_s    = '0;
    exit_nx_s    = difftest_exit;

    // Commits only count while running; DRAIN and EXIT ignore them.
    if (state_r == ST_RUN) begin
      inc_s = popcount(commit_valid);
    end else begin
      inc_s = '0;
    end
    total_s = pending_r + inc_s;

    if (total_s > STEP_MAX_P) begin
      emit_val_s = STEP_MAX_P;
    end else begin
      emit_val_s = total_s;
    end
    residual_s = total_s - emit_val_s;

    // A trap entry drains like DRAIN does, so the trap batch goes out at once.
    trap_s = (state_r == ST_RUN) && trap_valid;
    emit_s = (total_s != '0) &&
             ((total_s >= THRESHOLD_P) ||
              force_flush ||
              ((timer_r >= TIMEOUT_P) && (pending_r != '0)) ||
              trap_s ||
              (state_r == ST_DRAIN));

    case (state_r)
      ST_RUN, ST_DRAIN: begin
        if (emit_s) begin
          step_nx_s    = emit_val_s[STEPWIDTH-1:0];
          pending_nx_s = residual_s;
          timer_nx_s   = '0;
        end else begin
          step_nx_s    = '0;
          pending_nx_s = total_s;
          if (total_s == '0) begin
            timer_nx_s = '0;
          end else if ((pending_r != '0) && (timer_r != TIMER_MAX_P)) begin
            timer_nx_s = timer_r + TW'(1);
          end else begin
            timer_nx_s = timer_r;
          end
        end

        if (trap_s) begin
          good_nx_s = trap_good;
          code_nx_s = trap_code;
        end else begin
          good_nx_s = good_r;
          code_nx_s = code_r;
        end

        // Leave for EXIT once nothing is left to step; exit rises one cycle
        // after the final step so the endpoint checks that batch first.
        if (trap_s || (state_r == ST_DRAIN)) begin
          if (pending_nx_s == '0) begin
            state_nx_s = ST_EXIT;
          end else begin
            state_nx_s = ST_DRAIN;
          end
        end else begin
          state_nx_s = state_r;
        end
      end

      ST_EXIT: begin
        step_nx_s  = '0;
        state_nx_s = ST_EXIT;
        if (good_r) begin
          exit_nx_s = 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (code_r == 32'h0) begin
          // A zero code would read as "running"; report it as 1 instead.
          exit_nx_s = 64'h0000_0000_0000_0001;
        end else begin
          exit_nx_s = {32'h0, code_r};
        end
      end

      default: begin
        state_nx_s   = ST_RUN;
        pending_nx_s = '0;
        timer_nx_s   = '0;
        step_nx_s    = '0;
      end
    endcase
  end

  // State, batch bookkeeping and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_RUN;
      pending_r     <= '0;
      timer_r       <= '0;
      good_r        <= 1'b0;
      code_r        <= 32'h0;
      difftest_step <= '0;
      difftest_exit <= 64'h0;
    end else begin
      state_r       <= state_nx_s;
      pending_r     <= pending_nx_s;
      timer_r       <= timer_nx_s;
      good_r        <= good_nx_s;
      code_r        <= code_nx_s;
      difftest_step <= step_nx_s;
      difftest_exit <= exit_nx_s;
    end
  end

`ifdef DIFFTEST_BATCH_STATS_EN
  // Emission statistics, updated on the same edge as difftest_step.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_batches <= 32'h0;
      stat_commits <= 64'h0;
    end else if (step_nx_s != '0) begin
      stat_batches <= stat_batches + 32'h1;
      stat_commits <= stat_commits + 64'(step_nx_s);
    end else begin
      stat_batches <= stat_batches;
      stat_commits <= stat_commits;
    end
  end
`endif

endmodule
